// File: rtl/sat_pkg.sv
// Shared SAT clause-tracking definitions: parameter defaults, op encoding,
// and the literal bit-index convention used by the accumulator and its evaluator.
package sat_pkg;

  localparam int unsigned NUM_CLAUSES_DEF           = 64;
  localparam int unsigned NUM_CLAUSES_PER_CYCLE_DEF = 16;
  localparam int unsigned NUM_VARS_PER_CLAUSE_DEF   = 3;
  localparam int unsigned OP_BITS                   = 2;

  // Encoding 3 is reserved and behaves as OP_READ.
  typedef enum logic [OP_BITS-1:0] {
    OP_SET  = 2'd0,
    OP_CLR  = 2'd1,
    OP_READ = 2'd2
  } op_e;

  // Literal v of clause c lives at bit c*nv + v; a set bit means the literal is false.
  function automatic int unsigned lit_idx(input int unsigned c,
                                          input int unsigned v,
                                          input int unsigned nv);
    return c * nv + v;
  endfunction

endpackage

// File: rtl/clause_status_eval.sv
// Combinational per-clause status for one batch: counts false literals and flags
// clauses that are fully false (conflict) or have a single remaining literal (unit).
module clause_status_eval
  import sat_pkg::*;
#(
  parameter int unsigned NUM_CLAUSES_PER_CYCLE = NUM_CLAUSES_PER_CYCLE_DEF,
  parameter int unsigned NUM_VARS_PER_CLAUSE   = NUM_VARS_PER_CLAUSE_DEF,
  localparam int unsigned W = NUM_CLAUSES_PER_CYCLE * NUM_VARS_PER_CLAUSE
) (
  input  logic [W-1:0]                     mask_i,
  output logic [NUM_CLAUSES_PER_CYCLE-1:0] conflict_o,
  output logic [NUM_CLAUSES_PER_CYCLE-1:0] unit_o
);

  localparam int unsigned CNTW = $clog2(NUM_VARS_PER_CLAUSE + 1);

  logic [CNTW-1:0] cnt;

  always_comb begin
    cnt        = '0;
    conflict_o = '0;
    unit_o     = '0;
    for (int unsigned c = 0; c < NUM_CLAUSES_PER_CYCLE; c++) begin
      cnt = '0;
      for (int unsigned v = 0; v < NUM_VARS_PER_CLAUSE; v++) begin
        cnt = cnt + CNTW'(mask_i[lit_idx(c, v, NUM_VARS_PER_CLAUSE)]);
      end
      conflict_o[c] = (cnt == CNTW'(NUM_VARS_PER_CLAUSE));
      unit_o[c]     = (cnt == CNTW'(NUM_VARS_PER_CLAUSE - 1));
    end
  end

endmodule

// File: rtl/clause_false_accumulator.sv
// Batched false-literal store for a SAT engine: SET/CLR/READ one batch per cycle,
// returning the updated mask with conflict/unit flags through a one-deep output stage.
module clause_false_accumulator
  import sat_pkg::*;
#(
  parameter int unsigned NUM_CLAUSES           = NUM_CLAUSES_DEF,
  parameter int unsigned NUM_CLAUSES_PER_CYCLE = NUM_CLAUSES_PER_CYCLE_DEF,
  parameter int unsigned NUM_VARS_PER_CLAUSE   = NUM_VARS_PER_CLAUSE_DEF,
  localparam int unsigned NUM_BATCHES = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE,
  localparam int unsigned BATCH_BITS  = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1,
  localparam int unsigned W           = NUM_CLAUSES_PER_CYCLE * NUM_VARS_PER_CLAUSE
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear_all,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [OP_BITS-1:0]               in_op,
  input  logic [BATCH_BITS-1:0]            in_batch_idx,
  input  logic [W-1:0]                     in_mask,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [BATCH_BITS-1:0]            out_batch_idx,
  output logic [W-1:0]                     out_assignments,
  output logic [NUM_CLAUSES_PER_CYCLE-1:0] out_conflict,
  output logic [NUM_CLAUSES_PER_CYCLE-1:0] out_unit,
  output logic                             conflict_seen,
  output logic                             idx_err
);

  localparam int unsigned IDXW = BATCH_BITS + 1;

  logic [NUM_BATCHES-1:0][W-1:0]    store_q, store_d;
  logic                             out_valid_q, out_valid_d;
  logic [BATCH_BITS-1:0]            out_batch_q, out_batch_d;
  logic [W-1:0]                     out_assign_q, out_assign_d;
  logic [NUM_CLAUSES_PER_CYCLE-1:0] out_conflict_q, out_conflict_d;
  logic [NUM_CLAUSES_PER_CYCLE-1:0] out_unit_q, out_unit_d;
  logic                             conflict_seen_q, conflict_seen_d;
  logic                             idx_err_q, idx_err_d;

  logic                             accept;
  logic                             idx_ok;
  logic [W-1:0]                     old_mask;
  logic [W-1:0]                     new_mask;
  logic [NUM_CLAUSES_PER_CYCLE-1:0] conflict_c;
  logic [NUM_CLAUSES_PER_CYCLE-1:0] unit_c;

  // Read the addressed batch and apply the op; the result feeds both the store and the output stage.
  always_comb begin
    idx_ok   = (IDXW'(in_batch_idx) < IDXW'(NUM_BATCHES));
    old_mask = '0;
    for (int unsigned b = 0; b < NUM_BATCHES; b++) begin
      if (in_batch_idx == BATCH_BITS'(b)) old_mask = store_q[b];
    end
    case (in_op)
      OP_SET:  new_mask = old_mask | in_mask;
      OP_CLR:  new_mask = old_mask & ~in_mask;
      default: new_mask = old_mask;
    endcase
  end

  clause_status_eval #(
    .NUM_CLAUSES_PER_CYCLE(NUM_CLAUSES_PER_CYCLE),
    .NUM_VARS_PER_CLAUSE  (NUM_VARS_PER_CLAUSE)
  ) u_eval (
    .mask_i    (new_mask),
    .conflict_o(conflict_c),
    .unit_o    (unit_c)
  );

  assign in_ready = rst_n && !clear_all && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    store_d         = store_q;
    out_valid_d     = out_valid_q;
    out_batch_d     = out_batch_q;
    out_assign_d    = out_assign_q;
    out_conflict_d  = out_conflict_q;
    out_unit_d      = out_unit_q;
    conflict_seen_d = conflict_seen_q;
    idx_err_d       = 1'b0;

    if (clear_all) begin
      store_d         = '0;
      out_valid_d     = 1'b0;
      conflict_seen_d = 1'b0;
    end else begin
      if (out_ready) out_valid_d = 1'b0;
      idx_err_d = accept && !idx_ok;
      if (accept && idx_ok) begin
        for (int unsigned b = 0; b < NUM_BATCHES; b++) begin
          if (in_batch_idx == BATCH_BITS'(b)) store_d[b] = new_mask;
        end
        out_valid_d     = 1'b1;
        out_batch_d     = in_batch_idx;
        out_assign_d    = new_mask;
        out_conflict_d  = conflict_c;
        out_unit_d      = unit_c;
        conflict_seen_d = conflict_seen_q || (|conflict_c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      store_q         <= '0;
      out_valid_q     <= 1'b0;
      out_batch_q     <= '0;
      out_assign_q    <= '0;
      out_conflict_q  <= '0;
      out_unit_q      <= '0;
      conflict_seen_q <= 1'b0;
      idx_err_q       <= 1'b0;
    end else begin
      store_q         <= store_d;
      out_valid_q     <= out_valid_d;
      out_batch_q     <= out_batch_d;
      out_assign_q    <= out_assign_d;
      out_conflict_q  <= out_conflict_d;
      out_unit_q      <= out_unit_d;
      conflict_seen_q <= conflict_seen_d;
      idx_err_q       <= idx_err_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_batch_idx   = out_batch_q;
  assign out_assignments = out_assign_q;
  assign out_conflict    = out_conflict_q;
  assign out_unit        = out_unit_q;
  assign conflict_seen   = conflict_seen_q;
  assign idx_err         = idx_err_q;

endmodule

// File: tb/tb_clause_false_accumulator.sv
// Directed bench: default 64-clause instance for the main paths, 48-clause instance
// for the out-of-range batch index.
module tb_clause_false_accumulator;
  import sat_pkg::*;

  localparam int unsigned W  = 48;
  localparam int unsigned NC = 16;
  localparam int unsigned BB = 2;

  logic clk = 1'b0;
  logic rst_n, clear_all;
  logic in_valid, in_ready, out_valid, out_ready, conflict_seen, idx_err;
  logic [1:0] in_op;
  logic [BB-1:0] in_batch_idx, out_batch_idx;
  logic [W-1:0] in_mask, out_assignments;
  logic [NC-1:0] out_conflict, out_unit;

  logic b_clear_all, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_conflict_seen, b_idx_err;
  logic [1:0] b_in_op;
  logic [BB-1:0] b_in_batch_idx, b_out_batch_idx;
  logic [W-1:0] b_in_mask, b_out_assignments;
  logic [NC-1:0] b_out_conflict, b_out_unit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clause_false_accumulator dut (
    .clk(clk), .rst_n(rst_n), .clear_all(clear_all),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_batch_idx(in_batch_idx), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_batch_idx(out_batch_idx),
    .out_assignments(out_assignments), .out_conflict(out_conflict), .out_unit(out_unit),
    .conflict_seen(conflict_seen), .idx_err(idx_err)
  );

  clause_false_accumulator #(.NUM_CLAUSES(48), .NUM_CLAUSES_PER_CYCLE(16)) dut48 (
    .clk(clk), .rst_n(rst_n), .clear_all(b_clear_all),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op),
    .in_batch_idx(b_in_batch_idx), .in_mask(b_in_mask),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_batch_idx(b_out_batch_idx),
    .out_assignments(b_out_assignments), .out_conflict(b_out_conflict), .out_unit(b_out_unit),
    .conflict_seen(b_conflict_seen), .idx_err(b_idx_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear_all = 1'b0; in_valid = 1'b0; in_op = 2'd2; in_batch_idx = '0;
    in_mask = '0; out_ready = 1'b1;
    b_clear_all = 1'b0; b_in_valid = 1'b0; b_in_op = 2'd2; b_in_batch_idx = '0;
    b_in_mask = '0; b_out_ready = 1'b1;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0h exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0h exp 0", out_valid); end
    checks++; if (out_batch_idx !== 2'd0) begin errors++; $display("FAIL rst_batch got %0h exp 0", out_batch_idx); end
    checks++; if (out_assignments !== 48'h0) begin errors++; $display("FAIL rst_assign got %h exp 0", out_assignments); end
    checks++; if (out_conflict !== 16'h0) begin errors++; $display("FAIL rst_conflict got %h exp 0", out_conflict); end
    checks++; if (out_unit !== 16'h0) begin errors++; $display("FAIL rst_unit got %h exp 0", out_unit); end
    checks++; if (conflict_seen !== 1'b0) begin errors++; $display("FAIL rst_seen got %0h exp 0", conflict_seen); end
    checks++; if (idx_err !== 1'b0) begin errors++; $display("FAIL rst_idx_err got %0h exp 0", idx_err); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid got %0h exp 0", b_out_valid); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %0h exp 1", in_ready); end
  endtask

  task automatic test_read_zero();
    in_valid = 1'b1; in_op = 2'd2; in_batch_idx = 2'd2; in_mask = 48'hFFFF_FFFF_FFFF;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rd_valid got %0h exp 1", out_valid); end
    checks++; if (out_batch_idx !== 2'd2) begin errors++; $display("FAIL rd_batch got %0h exp 2", out_batch_idx); end
    checks++; if (out_assignments !== 48'h0) begin errors++; $display("FAIL rd_assign got %h exp 0", out_assignments); end
    checks++; if (out_conflict !== 16'h0) begin errors++; $display("FAIL rd_conflict got %h exp 0", out_conflict); end
    checks++; if (out_unit !== 16'h0) begin errors++; $display("FAIL rd_unit got %h exp 0", out_unit); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rd_drain got %0h exp 0", out_valid); end
  endtask

  // Second SET follows the first with no gap, so it must see the first write.
  task automatic test_set_conflict();
    in_valid = 1'b1; in_op = 2'd0; in_batch_idx = 2'd1; in_mask = 48'h3;
    tick();
    checks++; if (out_assignments !== 48'h3) begin errors++; $display("FAIL set1_assign got %h exp 3", out_assignments); end
    checks++; if (out_unit !== 16'h0001) begin errors++; $display("FAIL set1_unit got %h exp 0001", out_unit); end
    checks++; if (out_conflict !== 16'h0) begin errors++; $display("FAIL set1_conflict got %h exp 0", out_conflict); end
    checks++; if (conflict_seen !== 1'b0) begin errors++; $display("FAIL set1_seen got %0h exp 0", conflict_seen); end
    in_mask = 48'h4;
    tick();
    in_valid = 1'b0;
    checks++; if (out_assignments !== 48'h7) begin errors++; $display("FAIL set2_assign got %h exp 7", out_assignments); end
    checks++; if (out_conflict !== 16'h0001) begin errors++; $display("FAIL set2_conflict got %h exp 0001", out_conflict); end
    checks++; if (out_unit !== 16'h0) begin errors++; $display("FAIL set2_unit got %h exp 0", out_unit); end
    checks++; if (conflict_seen !== 1'b1) begin errors++; $display("FAIL set2_seen got %0h exp 1", conflict_seen); end
  endtask

  task automatic test_clr();
    in_valid = 1'b1; in_op = 2'd1; in_batch_idx = 2'd1; in_mask = 48'h4;
    tick();
    in_valid = 1'b0;
    checks++; if (out_assignments !== 48'h3) begin errors++; $display("FAIL clr_assign got %h exp 3", out_assignments); end
    checks++; if (out_unit !== 16'h0001) begin errors++; $display("FAIL clr_unit got %h exp 0001", out_unit); end
    checks++; if (out_conflict !== 16'h0) begin errors++; $display("FAIL clr_conflict got %h exp 0", out_conflict); end
    checks++; if (conflict_seen !== 1'b1) begin errors++; $display("FAIL clr_seen got %0h exp 1", conflict_seen); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'd2; in_batch_idx = 2'd0; in_mask = '0;
    tick();
    in_op = 2'd0; in_batch_idx = 2'd0; in_mask = 48'h1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %0h exp 0", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %0h exp 1", i, out_valid); end
      checks++; if (out_assignments !== 48'h0) begin errors++; $display("FAIL bp_assign[%0d] got %h exp 0", i, out_assignments); end
      checks++; if (out_batch_idx !== 2'd0) begin errors++; $display("FAIL bp_batch[%0d] got %0h exp 0", i, out_batch_idx); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0h exp 1", in_ready); end
    tick();
    checks++; if (out_assignments !== 48'h1) begin errors++; $display("FAIL bp_r1_assign got %h exp 1", out_assignments); end
    in_batch_idx = 2'd3; in_mask = 48'h100;
    tick();
    in_valid = 1'b0;
    checks++; if (out_batch_idx !== 2'd3) begin errors++; $display("FAIL bp_r2_batch got %0h exp 3", out_batch_idx); end
    checks++; if (out_assignments !== 48'h100) begin errors++; $display("FAIL bp_r2_assign got %h exp 100", out_assignments); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0h exp 0", out_valid); end
  endtask

  task automatic test_clear_all();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'd0; in_batch_idx = 2'd2; in_mask = 48'h7;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clrall_pre_valid got %0h exp 1", out_valid); end
    clear_all = 1'b1; in_batch_idx = 2'd0; in_mask = 48'hFFFF_FFFF_FFFF;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clrall_in_ready got %0h exp 0", in_ready); end
    tick();
    clear_all = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clrall_valid got %0h exp 0", out_valid); end
    checks++; if (conflict_seen !== 1'b0) begin errors++; $display("FAIL clrall_seen got %0h exp 0", conflict_seen); end
    in_valid = 1'b1; in_op = 2'd2; in_mask = '0;
    for (int b = 0; b < 4; b++) begin
      in_batch_idx = BB'(b);
      tick();
      checks++; if (out_batch_idx !== BB'(b)) begin errors++; $display("FAIL clrall_rd_batch[%0d] got %0h", b, out_batch_idx); end
      checks++; if (out_assignments !== 48'h0) begin errors++; $display("FAIL clrall_rd_assign[%0d] got %h exp 0", b, out_assignments); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_idx_err();
    b_in_valid = 1'b1; b_in_op = 2'd0; b_in_batch_idx = 2'd1; b_in_mask = 48'h5;
    tick();
    checks++; if (b_out_assignments !== 48'h5) begin errors++; $display("FAIL ie_pre_assign got %h exp 5", b_out_assignments); end
    b_in_batch_idx = 2'd3; b_in_mask = 48'hFFFF_FFFF_FFFF;
    #1;
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL ie_in_ready got %0h exp 1", b_in_ready); end
    tick();
    b_in_valid = 1'b0;
    checks++; if (b_idx_err !== 1'b1) begin errors++; $display("FAIL ie_pulse got %0h exp 1", b_idx_err); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL ie_valid got %0h exp 0", b_out_valid); end
    tick();
    checks++; if (b_idx_err !== 1'b0) begin errors++; $display("FAIL ie_pulse_end got %0h exp 0", b_idx_err); end
    b_in_valid = 1'b1; b_in_op = 2'd3; b_in_mask = '0;
    b_in_batch_idx = 2'd1;
    tick();
    checks++; if (b_out_assignments !== 48'h5) begin errors++; $display("FAIL ie_rd1 got %h exp 5", b_out_assignments); end
    b_in_batch_idx = 2'd0;
    tick();
    checks++; if (b_out_assignments !== 48'h0) begin errors++; $display("FAIL ie_rd0 got %h exp 0", b_out_assignments); end
    b_in_batch_idx = 2'd2;
    tick();
    b_in_valid = 1'b0;
    checks++; if (b_out_assignments !== 48'h0) begin errors++; $display("FAIL ie_rd2 got %h exp 0", b_out_assignments); end
    checks++; if (b_conflict_seen !== 1'b0) begin errors++; $display("FAIL ie_seen got %0h exp 0", b_conflict_seen); end
  endtask

  initial begin
    test_reset();
    test_read_zero();
    test_set_conflict();
    test_clr();
    test_backpressure();
    test_clear_all();
    test_idx_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clause_false_accumulator.md
CLAUSE_FALSE_ACCUMULATOR -- requirements
Module: clause_false_accumulator

Interface
REQ-001 SHALL have parameter NUM_CLAUSES, default 64: total clauses held.
REQ-002 SHALL have parameter NUM_CLAUSES_PER_CYCLE, default 16: clauses per batch.
REQ-003 SHALL have parameter NUM_VARS_PER_CLAUSE, default 3: literals per clause.
REQ-004 SHALL derive NUM_BATCHES = NUM_CLAUSES/NUM_CLAUSES_PER_CYCLE, BATCH_BITS = max(1, clog2(NUM_BATCHES)), and W = NUM_CLAUSES_PER_CYCLE*NUM_VARS_PER_CLAUSE.
REQ-005 SHALL have port: clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port: clear_all  input  1  synchronous wipe of all stored literal state.
REQ-008 SHALL have port: in_valid  input  1  request valid.
REQ-009 SHALL have port: in_ready  output  1  request accepted when in_valid and in_ready are both high.
REQ-010 SHALL have port: in_op  input  2  operation: 0 SET (OR in), 1 CLR (AND-NOT, backtrack), 2 READ, 3 reserved (treated as READ).
REQ-011 SHALL have port: in_batch_idx  input  BATCH_BITS  target batch.
REQ-012 SHALL have port: in_mask  input  W  literal bits; bit c*NUM_VARS_PER_CLAUSE+v is literal v of clause c; 1 means false.
REQ-013 SHALL have port: out_valid  output  1  result valid.
REQ-014 SHALL have port: out_ready  input  1  downstream accepts result.
REQ-015 SHALL have port: out_batch_idx  output  BATCH_BITS  batch of the result.
REQ-016 SHALL have port: out_assignments  output  W  post-operation stored mask for the batch.
REQ-017 SHALL have port: out_conflict  output  NUM_CLAUSES_PER_CYCLE  clause has all literals false.
REQ-018 SHALL have port: out_unit  output  NUM_CLAUSES_PER_CYCLE  clause has exactly one literal not false.
REQ-019 SHALL have port: conflict_seen  output  1  sticky flag; set on any conflict result since the last clear.
REQ-020 SHALL have port: idx_err  output  1  one-cycle pulse for a request with an out-of-range batch index.

Function
REQ-021 SHALL store NUM_CLAUSES*NUM_VARS_PER_CLAUSE literal bits in flops.
REQ-022 SHALL on accept update the addressed batch at the same edge: SET gives new = old | in_mask; CLR gives new = old & ~in_mask; READ gives new = old.
REQ-023 SHALL register new, its conflict/unit vectors and the batch index into the output stage at the accepting edge; latency is 1 cycle.
REQ-024 SHALL drive in_ready = !clear_all && (!out_valid || out_ready), so full throughput is sustained under continuous out_ready.
REQ-025 SHALL make back-to-back requests to the same batch see the previous request's write, with no hazard bubble.
REQ-026 SHALL hold out_valid and all out_* stable until out_ready is high.
REQ-027 SHALL accept a request with in_batch_idx >= NUM_BATCHES (reachable only for non-power-of-two NUM_BATCHES), leave storage unchanged, produce no result, and pulse idx_err in the following cycle.
REQ-028 SHALL on clear_all zero all storage and conflict_seen at that edge and drop any pending output (out_valid becomes 0); clear_all takes priority over a simultaneous request.
REQ-029 SHALL set conflict_seen when a result with nonzero out_conflict is loaded into the output stage; a CLR alone does not clear it.
REQ-030 SHALL compute conflict and unit purely from the post-operation mask (popcount per clause).

Reset
REQ-031 SHALL on rst_n low at a clock edge zero all storage and drive out_valid=0, out_batch_idx=0, out_assignments=0, out_conflict=0, out_unit=0, conflict_seen=0, idx_err=0; in_ready=0 while rst_n is low.
REQ-032 SHALL treat reset mid-transaction as discarding the transaction, with no partial write.

Structure
REQ-033 SHALL place the parameter defaults, the op encoding enum (OP_SET, OP_CLR, OP_READ) and the literal bit-index convention in shared package sat_pkg.
REQ-034 SHALL implement per-batch conflict/unit evaluation in combinational sub-module clause_status_eval (mask in, conflict/unit vectors out).

Verification
REQ-035 Bench SHALL cover: reset, then READ batch 2 -> out_assignments=0, out_conflict=0, out_unit=0, 1 cycle after accept.
REQ-036 Bench SHALL cover: SET batch 1 mask=0x3 (clause 0 lits 0,1) -> out_unit[0]=1, out_conflict=0; then SET batch 1 mask=0x4 -> out_assignments=0x7, out_conflict[0]=1, conflict_seen=1.
REQ-037 Bench SHALL cover: CLR batch 1 mask=0x4 after REQ-036 -> out_assignments=0x3, out_unit[0]=1, conflict_seen stays 1.
REQ-038 Bench SHALL cover: out_ready held low 3 cycles with in_valid high -> in_ready=0, outputs stable; one result per cycle after release, no loss or duplication.
REQ-039 Bench SHALL cover: clear_all asserted in the same cycle as a SET -> request not accepted, storage all 0, out_valid=0, conflict_seen=0.
REQ-040 Bench SHALL cover: NUM_CLAUSES=48, NUM_CLAUSES_PER_CYCLE=16, request to batch 3 -> idx_err pulse, no out_valid, storage unchanged.
